mem_wb_stage: RTL and testbench

Memory/writeback controller that consumes the X→M pipeline register outputs of the 3-stage RISC-V core. It issues data-memory requests over a ready/valid handshake and formats load data by funct3. It drives the register-file write port and produces the `stall` that freezes upstream pipeline registers while a memory access is outstanding.

---
 rtl/mem_wb_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Memory / writeback controller fed by the X->M pipeline register of the
// 3-stage RISC-V core. Issues data-memory requests over a ready/valid
// handshake, formats returned load data by funct3, drives the register-file
// write port and raises stall while a memory access is outstanding.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   funct3_m          : load/store width and signedness of the M instruction
//   wb_sel_m          : writeback source (0 load, 1 ALU, 2 PC+4, 3 ALU)
//   reg_we_m          : instruction writes rd
//   dmem_rw_m         : byte write enables (nonzero = store)
//   kill_m            : M instruction squashed
//   alu_m             : ALU result / memory address
//   pc4_m             : PC+4
//   store_data_m      : lane-aligned store data
//   rd_m              : destination register
//   mem_req/we/addr/wdata : request side of the data-memory handshake
//   mem_ready         : memory accepts the request this cycle
//   mem_rvalid/rdata  : read data return
//   stall             : freeze upstream pipeline registers
//   rf_we/wa/wd       : register-file write port
// ---------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      funct3_m,
   input  logic [1:0]      wb_sel_m,
   input  logic            reg_we_m,
   input  logic [3:0]      dmem_rw_m,
   input  logic            kill_m,
   input  logic [XLEN-1:0] alu_m,
   input  logic [XLEN-1:0] pc4_m,
   input  logic [XLEN-1:0] store_data_m,
   input  logic [4:0]      rd_m,
   output logic            mem_req,
   output logic [3:0]      mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ready,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            stall,
   output logic            rf_we,
   output logic [4:0]      rf_wa,
   output logic [XLEN-1:0] rf_wd
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_ACK  = 2'd1,
      S_WAIT_DATA = 2'd2,
      S_WB        = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   // Request captured at issue time; replayed while waiting for acceptance.
   logic [XLEN-1:0]   r_addr;
   logic [3:0]        r_we;
   logic [XLEN-1:0]   r_wdata;
   logic [2:0]        r_funct3;
   logic [4:0]        r_rd;
   logic [1:0]        r_off;
   logic              r_is_load;
   logic [XLEN-1:0]   r_data;
   // Set when a held store is accepted while stall is still high: the same
   // store is still presented in M on the next cycle and must not reissue.
   logic              r_done;

   logic              w_store;
   logic              w_load;
   logic              w_issue;
   logic              w_stall_int;
   logic              w_done_next;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [XLEN-1:0]   w_ld_fmt;

   // A store wins if an instruction would otherwise look like both.
   assign w_store = !kill_m && (dmem_rw_m != 4'h0);
   assign w_load  = !kill_m && reg_we_m && (wb_sel_m == 2'd0) && !w_store;

   // Load data formatting from the latched byte offset and funct3.
   always_comb begin
      w_byte = 8'h00;
      case (r_off)
         2'd0: w_byte = mem_rdata[7:0];
         2'd1: w_byte = mem_rdata[15:8];
         2'd2: w_byte = mem_rdata[23:16];
         2'd3: w_byte = mem_rdata[31:24];
         default: w_byte = 8'h00;
      endcase
      w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      w_ld_fmt = mem_rdata;
      case (r_funct3)
         3'b000:  w_ld_fmt = {{(XLEN-8){w_byte[7]}}, w_byte};
         3'b001:  w_ld_fmt = {{(XLEN-16){w_half[15]}}, w_half};
         3'b100:  w_ld_fmt = {{(XLEN-8){1'b0}}, w_byte};
         3'b101:  w_ld_fmt = {{(XLEN-16){1'b0}}, w_half};
         default: w_ld_fmt = mem_rdata;
      endcase
   end

   // Next-state and output logic.
   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_stall_int  = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 4'h0;
      mem_addr     = '0;
      mem_wdata    = '0;
      stall        = 1'b0;
      rf_we        = 1'b0;
      rf_wa        = 5'd0;
      rf_wd        = '0;

      case (r_state)
         S_IDLE: begin
            if (r_done) begin
               // Store already accepted; let the pipeline advance.
            end else if (w_store || w_load) begin
               w_issue   = 1'b1;
               mem_req   = 1'b1;
               mem_we    = w_store ? dmem_rw_m : 4'h0;
               mem_addr  = {alu_m[XLEN-1:2], 2'b00};
               mem_wdata = store_data_m;
               if (w_store) begin
                  if (!mem_ready) begin
                     w_stall_int  = 1'b1;
                     w_state_next = S_WAIT_ACK;
                  end
               end else begin
                  w_stall_int  = 1'b1;
                  w_state_next = mem_ready ? S_WAIT_DATA : S_WAIT_ACK;
               end
            end else if (!kill_m) begin
               rf_we = reg_we_m && (rd_m != 5'd0);
               rf_wa = rd_m;
               rf_wd = (wb_sel_m == 2'd2) ? pc4_m : alu_m;
            end
         end
         S_WAIT_ACK: begin
            mem_req     = 1'b1;
            mem_we      = r_we;
            mem_addr    = r_addr;
            mem_wdata   = r_wdata;
            w_stall_int = 1'b1;
            if (mem_ready) begin
               w_state_next = r_is_load ? S_WAIT_DATA : S_IDLE;
            end
         end
         S_WAIT_DATA: begin
            w_stall_int = 1'b1;
            if (mem_rvalid) begin
               w_state_next = S_WB;
            end
         end
         S_WB: begin
            rf_we        = (r_rd != 5'd0);
            rf_wa        = r_rd;
            rf_wd        = r_data;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase

      stall = w_stall_int;

      // Outputs are held at zero for the whole reset assertion, not just
      // after the first edge.
      if (rst) begin
         mem_req   = 1'b0;
         mem_we    = 4'h0;
         mem_addr  = '0;
         mem_wdata = '0;
         stall     = 1'b0;
         rf_we     = 1'b0;
         rf_wa     = 5'd0;
         rf_wd     = '0;
      end
   end

   assign w_done_next = w_stall_int
                      ? (r_done || ((r_state == S_WAIT_ACK) && mem_ready && !r_is_load))
                      : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr    <= '0;
         r_we      <= 4'h0;
         r_wdata   <= '0;
         r_funct3  <= 3'd0;
         r_rd      <= 5'd0;
         r_off     <= 2'd0;
         r_is_load <= 1'b0;
         r_data    <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_done_next;
         if (w_issue) begin
            r_addr    <= {alu_m[XLEN-1:2], 2'b00};
            r_we      <= w_store ? dmem_rw_m : 4'h0;
            r_wdata   <= store_data_m;
            r_funct3  <= funct3_m;
            r_rd      <= rd_m;
            r_off     <= alu_m[1:0];
            r_is_load <= w_load;
         end
         if ((r_state == S_WAIT_DATA) && mem_rvalid) begin
            r_data <= w_ld_fmt;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed bench for mem_wb_stage. Inputs change on the falling edge and
// outputs are sampled 1 ns later. Expected register-file writes are queued
// when an instruction is driven and popped whenever rf_we is observed.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  funct3_m;
   logic [1:0]  wb_sel_m;
   logic        reg_we_m;
   logic [3:0]  dmem_rw_m;
   logic        kill_m;
   logic [31:0] alu_m;
   logic [31:0] pc4_m;
   logic [31:0] store_data_m;
   logic [4:0]  rd_m;
   logic        mem_req;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        stall;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;

   typedef struct packed {
      logic [4:0]  wa;
      logic [31:0] wd;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  n_acc  = 0;

   mem_wb_stage #(.XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .funct3_m     (funct3_m),
      .wb_sel_m     (wb_sel_m),
      .reg_we_m     (reg_we_m),
      .dmem_rw_m    (dmem_rw_m),
      .kill_m       (kill_m),
      .alu_m        (alu_m),
      .pc4_m        (pc4_m),
      .store_data_m (store_data_m),
      .rd_m         (rd_m),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .stall        (stall),
      .rf_we        (rf_we),
      .rf_wa        (rf_wa),
      .rf_wd        (rf_wd)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Close out the current cycle: count accepted requests, retire any
   // register-file write against the scoreboard, move to the next negedge.
   task automatic next();
      wr_t w;
      if (mem_req && mem_ready) n_acc++;
      if (rf_we) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected_write observed=rd%0d/%h expected=no write", rf_wa, rf_wd);
         end
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("sb_wa", 32'(rf_wa), 32'(w.wa));
            chk("sb_wd", rf_wd, w.wd);
         end
      end
      @(negedge clk);
   endtask

   task automatic nop();
      funct3_m     = 3'd0;
      wb_sel_m     = 2'd1;
      reg_we_m     = 1'b0;
      dmem_rw_m    = 4'h0;
      kill_m       = 1'b0;
      mem_ready    = 1'b0;
      mem_rvalid   = 1'b0;
   endtask

   task automatic plain(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [4:0] rd);
      nop();
      wb_sel_m = sel; reg_we_m = 1'b1; alu_m = alu; pc4_m = pc4; rd_m = rd;
      if (rd != 5'd0) exp_q.push_back('{wa: rd, wd: (sel == 2'd2) ? pc4 : alu});
      #1;
      chk("plain_we", 32'(rf_we), (rd != 5'd0) ? 32'd1 : 32'd0);
      chk("plain_stall", 32'(stall), 32'd0);
      chk("plain_req", 32'(mem_req), 32'd0);
      next();
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [31:0] exp, input int dly);
      nop();
      funct3_m = f3; wb_sel_m = 2'd0; reg_we_m = 1'b1; alu_m = addr; rd_m = 5'd9;
      exp_q.push_back('{wa: 5'd9, wd: exp});
      for (int i = 0; i <= dly; i++) begin
         mem_ready = (i == dly);
         #1;
         chk("ld_req", 32'(mem_req), 32'd1);
         chk("ld_we", 32'(mem_we), 32'd0);
         chk("ld_addr", mem_addr, {addr[31:2], 2'b00});
         chk("ld_stall", 32'(stall), 32'd1);
         next();
      end
      mem_ready = 1'b0;
      #1;
      chk("ld_wait_req", 32'(mem_req), 32'd0);
      chk("ld_wait_stall", 32'(stall), 32'd1);
      next();
      mem_rvalid = 1'b1; mem_rdata = rdata;
      #1;
      chk("ld_rvalid_stall", 32'(stall), 32'd1);
      next();
      mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_A5A5;
      #1;
      chk("ld_wb_stall", 32'(stall), 32'd0);
      chk("ld_wb_we", 32'(rf_we), 32'd1);
      next();
      nop();
   endtask

   initial begin
      rst = 1'b1;
      nop();
      alu_m = 32'h0000_0104; pc4_m = 32'h0000_0008; store_data_m = 32'h0; rd_m = 5'd3;
      mem_rdata = 32'h0;
      // Load-shaped inputs during reset must not leak onto the outputs.
      wb_sel_m = 2'd0; reg_we_m = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      nop();

      // Plain ALU / PC+4 writes and the x0 case.
      plain(2'd1, 32'h0000_1234, 32'h0000_0040, 5'd5);
      plain(2'd2, 32'h0000_7777, 32'h0000_0044, 5'd7);
      plain(2'd3, 32'hCAFE_0001, 32'h0000_0048, 5'd31);
      plain(2'd1, 32'h0000_1234, 32'h0000_004C, 5'd0);

      // Store accepted immediately.
      n_acc = 0;
      nop();
      dmem_rw_m = 4'hF; alu_m = 32'h0000_0203; store_data_m = 32'hDEAD_BEEF; mem_ready = 1'b1;
      #1;
      chk("st0_req", 32'(mem_req), 32'd1);
      chk("st0_we", 32'(mem_we), 32'hF);
      chk("st0_addr", mem_addr, 32'h0000_0200);
      chk("st0_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st0_stall", 32'(stall), 32'd0);
      next();
      nop();
      #1;
      chk("st0_after_req", 32'(mem_req), 32'd0);
      next();
      chk("st0_accepts", 32'(n_acc), 32'd1);

      // Store with ready delayed two cycles.
      n_acc = 0;
      dmem_rw_m = 4'h3; alu_m = 32'h0000_0310; store_data_m = 32'h0000_BEEF; mem_ready = 1'b0;
      #1;
      chk("st2_c0_stall", 32'(stall), 32'd1);
      chk("st2_c0_req", 32'(mem_req), 32'd1);
      next();
      alu_m = 32'hFFFF_FFFC; store_data_m = 32'h1111_1111;
      #1;
      chk("st2_c1_stall", 32'(stall), 32'd1);
      chk("st2_c1_addr", mem_addr, 32'h0000_0310);
      chk("st2_c1_wdata", mem_wdata, 32'h0000_BEEF);
      chk("st2_c1_we", 32'(mem_we), 32'h3);
      next();
      alu_m = 32'h0000_0310; store_data_m = 32'h0000_BEEF; mem_ready = 1'b1;
      #1;
      chk("st2_c2_stall", 32'(stall), 32'd1);
      chk("st2_c2_req", 32'(mem_req), 32'd1);
      next();
      #1;
      chk("st2_c3_req", 32'(mem_req), 32'd0);
      chk("st2_c3_stall", 32'(stall), 32'd0);
      next();
      nop();
      #1;
      chk("st2_c4_stall", 32'(stall), 32'd0);
      next();
      chk("st2_accepts", 32'(n_acc), 32'd1);

      // Loads of each width and sign.
      do_load(3'b000, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80, 0);
      do_load(3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080, 0);
      do_load(3'b001, 32'h0000_0102, 32'h8001_7FFF, 32'hFFFF_8001, 0);
      do_load(3'b101, 32'h0000_0102, 32'h8001_7FFF, 32'h0000_8001, 0);
      do_load(3'b001, 32'h0000_0100, 32'h8001_7FFF, 32'h0000_7FFF, 0);
      do_load(3'b000, 32'h0000_0101, 32'h1234_F056, 32'hFFFF_FFF0, 1);
      do_load(3'b010, 32'h0000_0108, 32'h1234_5678, 32'h1234_5678, 2);
      do_load(3'b111, 32'h0000_0101, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 0);

      // Killed load.
      nop();
      kill_m = 1'b1; wb_sel_m = 2'd0; reg_we_m = 1'b1; alu_m = 32'h0000_0400; rd_m = 5'd4;
      mem_ready = 1'b1;
      #1;
      chk("kill_req", 32'(mem_req), 32'd0);
      chk("kill_we", 32'(rf_we), 32'd0);
      chk("kill_stall", 32'(stall), 32'd0);
      next();
      nop();

      // Reset while waiting for load data; a late rvalid must be dropped.
      wb_sel_m = 2'd0; reg_we_m = 1'b1; alu_m = 32'h0000_0500; rd_m = 5'd12; mem_ready = 1'b1;
      #1;
      chk("rstmid_issue", 32'(mem_req), 32'd1);
      next();
      rst = 1'b1;
      #1;
      chk("rstmid_req", 32'(mem_req), 32'd0);
      chk("rstmid_stall", 32'(stall), 32'd0);
      chk("rstmid_rf_we", 32'(rf_we), 32'd0);
      chk("rstmid_addr", mem_addr, 32'd0);
      chk("rstmid_wd", rf_wd, 32'd0);
      next();
      rst = 1'b0;
      nop();
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      #1;
      chk("late_rvalid_stall", 32'(stall), 32'd0);
      chk("late_rvalid_we", 32'(rf_we), 32'd0);
      next();
      mem_rvalid = 1'b0;
      #1;
      chk("post_rst_we", 32'(rf_we), 32'd0);
      chk("post_rst_stall", 32'(stall), 32'd0);
      next();
      plain(2'd1, 32'h0000_0ABC, 32'h0000_0050, 5'd6);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
